matmul_seq_ctrl: RTL and testbench
==================================

// Module: matmul_seq_ctrl
// PURPOSE
//  Sequencer that time-shares one external 8-bit FP multiply-accumulate unit
//    (y = a*b + c) across a full 3x3 x 3x3 matrix product.
//  Latches A and B on start, issues the 27 operand triples in fixed order,
//    collects the 9 results and signals done.
//  Sits between the matrix register file and the shared fp_mac datapath.
//  Number format: S|EEE|MMMM, bias 3, hidden 1. 0x00 and 0x80 encode zero.
// PARAMETERS
//  MAC_LAT  1  cycles from the mac_valid cycle to a valid mac_y (0 = combinational)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request a product; sampled only in IDLE
//  a_mat      in   72  A, row-major: a00=[7:0], a01=[15:8], ..., a22=[71:64]
//  b_mat      in   72  B, same packing
//  mac_valid  out  1   one-cycle issue strobe to fp_mac
//  mac_a      out  8   multiplicand A[i][k]
//  mac_b      out  8   multiplier B[k][j]
//  mac_c      out  8   running accumulator (0x00 when k==0)
//  mac_y      in   8   fp_mac result
//  busy       out  1   product in progress
//  done       out  1   one-cycle pulse; c_mat updated in the same cycle
//  c_mat      out  72  C = A*B, same packing (c00 = c1 = [7:0])
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, mac_valid=0, mac_a/b/c=0, c_mat=0,
//    all internal registers 0. Reset mid-product aborts and clears everything.
//  States: IDLE -> ISSUE -> WAIT (MAC_LAT cycles; skipped if 0) -> CAPT ->
//    ISSUE | FIN -> IDLE.
//  IDLE: start=1 at edge t0 latches a_mat/b_mat into shadow registers.
//    i=j=k=0, acc=0; busy=1 from t0+1. Inputs may then change freely.
//  Loop order: i outer, j middle, k inner. Element e=3i+j.
//  ISSUE: mac_valid=1 for 1 cycle. mac_a/b/c are held stable until capture.
//  Capture: mac_y is sampled exactly MAC_LAT cycles after the ISSUE cycle
//    and written into acc. One product costs MAC_LAT+1 cycles.
//  At k==2 capture: c_mat[8e+:8] <= mac_y and acc <= 0. Other c_mat bytes
//    are untouched until then, so c_mat shows old and new mixed while busy.
//  After e=8, k=2 capture: FIN cycle with done=1 and busy=0, then IDLE.
//    No skips: done asserts at t0+1+27*(MAC_LAT+1); MAC_LAT=1 gives t0+55.
//  start while busy (or during the FIN cycle) is ignored and not queued.
//  start in the cycle right after FIN is accepted (back-to-back allowed).
//  Counters wrap k:2->0 (j++), j:2->0 (i++). i never exceeds 2.
//  No arithmetic is done locally: all FP math is done by fp_mac, and
//    mac_y is used unmodified.
// CONFIGURATION
//  ZERO_SKIP_EN defined:
//    If shadow A[i][k][6:0]==0 or B[k][j][6:0]==0, the ISSUE/WAIT/CAPT
//      sequence is replaced by a single SKIP cycle: mac_valid=0, acc unchanged.
//      At k==2 the store of c_mat uses acc instead of mac_y.
//    An element whose 3 products are all skipped stores 0x00.
//  ZERO_SKIP_EN undefined:
//    Every product is issued; cycle count is fixed and data-independent.
// TESTING
//  (bench drives a behavioural fp_mac with MAC_LAT-cycle delay)
//  1 Reset: rst high 2 cycles mid-product -> busy=0, done=0, c_mat=0,
//    mac_valid=0; next start runs a full product.
//  2 A=I (0x30 diagonal, 0x00 elsewhere), B={0xA7,0x20,0x30,0x30,0x10,0x90,
//    0xA0,0x30,0x20}, MAC_LAT=1 -> c_mat==b_mat, done at t0+55,
//    27 mac_valid pulses.
//  3 Same as 2 with ZERO_SKIP_EN -> c_mat==b_mat, 9 mac_valid pulses,
//    done at t0+37.
//  4 A={0x10,0x90,0x20,0xA0,0x30,0x30,0xB8,0x38,0x27}, B as in 2
//    -> c_mat bytes equal the golden fp_mac model. Repeat with MAC_LAT=0
//    (done t0+28) and MAC_LAT=3 (done t0+109).
//  5 start held high continuously -> products run back-to-back, one idle
//    cycle between done and the next busy; a_mat changed while busy has no
//    effect on the current result.
//  6 Operand order check: the k-th mac_valid of element e presents
//    A[e/3][k], B[k][e%3]; mac_c=0x00 on each k==0 issue.

Source files
------------

// File: rtl/matmul_seq_ctrl_if.sv
// Bus between the matrix register file / shared fp_mac and matmul_seq_ctrl.
// The slave modport is the sequencer's view; master is the surrounding system.
interface matmul_seq_ctrl_if;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = 9 * EW;

    logic          start;
    logic [MW-1:0] a_mat;
    logic [MW-1:0] b_mat;
    logic          mac_valid;
    logic [EW-1:0] mac_a;
    logic [EW-1:0] mac_b;
    logic [EW-1:0] mac_c;
    logic [EW-1:0] mac_y;
    logic          busy;
    logic          done;
    logic [MW-1:0] c_mat;

    modport master (
        output start, a_mat, b_mat, mac_y,
        input  mac_valid, mac_a, mac_b, mac_c, busy, done, c_mat
    );

    modport slave (
        input  start, a_mat, b_mat, mac_y,
        output mac_valid, mac_a, mac_b, mac_c, busy, done, c_mat
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Time-shares one external FP8 multiply-accumulate unit across a 3x3 x 3x3 product.
// Optional feature macro: ZERO_SKIP_EN (skip products with a zero operand).
module matmul_seq_ctrl #(
    parameter int unsigned MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    matmul_seq_ctrl_if.slave bus
);
    localparam int unsigned EW        = 8;
    localparam int unsigned MW        = 9 * EW;
    localparam int unsigned WAIT_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
    localparam int unsigned WCW       = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SKIP, FIN} state_t;

    state_t         state, state_d;
    logic [MW-1:0]  a_sh, b_sh, c_q, c_d;
    logic [MW-1:0]  src_a, src_b;
    logic [1:0]     i_q, j_q, k_q, i_d, j_d, k_d;
    logic [3:0]     e_q;
    logic [EW-1:0]  acc_q, acc_d;
    logic [EW-1:0]  op_a, op_b;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           load, adv, go, last, skip;

    function automatic logic [EW-1:0] pick(input logic [MW-1:0] m, input logic [3:0] idx);
        return m[EW*idx +: EW];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state, counter advance and operand selection for the next issue
    always_comb begin
        state_d = state;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        c_d     = c_q;
        load    = 1'b0;
        adv     = 1'b0;
        go      = 1'b0;
        src_a   = a_sh;
        src_b   = b_sh;
        e_q     = 4'(3 * i_q + j_q);
        last    = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);

        case (state)
            IDLE: begin
                if (bus.start) begin
                    load  = 1'b1;
                    go    = 1'b1;
                    src_a = bus.a_mat;
                    src_b = bus.b_mat;
                    i_d   = 2'd0;
                    j_d   = 2'd0;
                    k_d   = 2'd0;
                    acc_d = '0;
                end
            end
            ISSUE: begin
                if (MAC_LAT == 0) begin
                    adv = 1'b1;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (wcnt_q == WCW'(WAIT_LAST)) adv = 1'b1;
                else                           wcnt_d = wcnt_q + WCW'(1);
            end
            SKIP:    adv = 1'b1;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Product complete: fold result (or unchanged acc on a skip) and step k/j/i
        if (adv) begin
            acc_d = (state == SKIP) ? acc_q : bus.mac_y;
            if (k_q == 2'd2) begin
                c_d[EW*e_q +: EW] = acc_d;
                acc_d = '0;
                k_d   = 2'd0;
                if (j_q == 2'd2) begin
                    j_d = 2'd0;
                    i_d = i_q + 2'd1;
                end else begin
                    j_d = j_q + 2'd1;
                end
            end else begin
                k_d = k_q + 2'd1;
            end
            if (last) begin
                state_d = FIN;
                i_d     = 2'd0;
                j_d     = 2'd0;
                k_d     = 2'd0;
            end else begin
                go = 1'b1;
            end
        end

        op_a = pick(src_a, 4'(3 * i_d + k_d));
        op_b = pick(src_b, 4'(3 * k_d + j_d));
`ifdef ZERO_SKIP_EN
        skip = (op_a[6:0] == 7'd0) || (op_b[6:0] == 7'd0);
`else
        skip = 1'b0;
`endif
        if (go) state_d = skip ? SKIP : ISSUE;
    end

    // Shadow matrices, counters, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh          <= '0;
            b_sh          <= '0;
            c_q           <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            acc_q         <= '0;
            wcnt_q        <= '0;
            bus.mac_valid <= 1'b0;
            bus.mac_a     <= '0;
            bus.mac_b     <= '0;
            bus.mac_c     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            if (load) begin
                a_sh <= bus.a_mat;
                b_sh <= bus.b_mat;
            end
            c_q           <= c_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            acc_q         <= acc_d;
            wcnt_q        <= wcnt_d;
            bus.mac_valid <= (state_d == ISSUE);
            if (state_d == ISSUE) begin
                bus.mac_a <= op_a;
                bus.mac_b <= op_b;
                bus.mac_c <= acc_d;
            end
            bus.busy <= (state_d == ISSUE) || (state_d == WAIT) || (state_d == SKIP);
            bus.done <= (state_d == FIN);
        end
    end

    assign bus.c_mat = c_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: three instances (MAC_LAT 0/1/3) each fed by
// a behavioural FP8 MAC; operand order and accumulator chaining tracked on MAC_LAT=1.
module tb_matmul_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef ZERO_SKIP_EN
    localparam int LAT_ID    = 37;
    localparam int PULSES_ID = 9;
`else
    localparam int LAT_ID    = 55;
    localparam int PULSES_ID = 27;
`endif

    logic [71:0] a_drv, b_drv;
    logic        start0, start1, start3;

    matmul_seq_ctrl_if bus0();
    matmul_seq_ctrl_if bus1();
    matmul_seq_ctrl_if bus3();

    assign bus0.a_mat = a_drv;  assign bus0.b_mat = b_drv;  assign bus0.start = start0;
    assign bus1.a_mat = a_drv;  assign bus1.b_mat = b_drv;  assign bus1.start = start1;
    assign bus3.a_mat = a_drv;  assign bus3.b_mat = b_drv;  assign bus3.start = start3;

    matmul_seq_ctrl #(.MAC_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    matmul_seq_ctrl #(.MAC_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    matmul_seq_ctrl #(.MAC_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // FP8 S|EEE|MMMM, bias 3, hidden 1; 0x00/0x80 are zero
    function automatic real fp8_val(input logic [7:0] x);
        real v;
        int  e;
        if (x[6:0] == 7'd0) return 0.0;
        v = 1.0 + real'(int'(x[3:0])) / 16.0;
        e = int'(x[6:4]) - 3;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[7] ? -v : v;
    endfunction

    function automatic logic [7:0] fp8_enc(input real v);
        logic s;
        real  m;
        int   e;
        int   q;
        s = (v < 0.0);
        m = s ? -v : v;
        if (m < 0.125) return 8'h00;
        m = m * 8.0;
        e = 0;
        while (m >= 2.0 && e < 8) begin m = m / 2.0; e++; end
        if (e > 7) return {s, 7'h7F};
        q = $rtoi((m - 1.0) * 16.0 + 0.5);
        if (q == 16) begin q = 0; e++; end
        if (e > 7) return {s, 7'h7F};
        if (e == 0 && q == 0) return 8'h00;
        return {s, 3'(e), 4'(q)};
    endfunction

    function automatic logic [7:0] fp8_mac(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return fp8_enc(fp8_val(a) * fp8_val(b) + fp8_val(c));
    endfunction

    function automatic logic [71:0] ref_mm(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c;
        logic [7:0]  acc;
        c = '0;
        for (int e = 0; e < 9; e++) begin
            acc = 8'h00;
            for (int k = 0; k < 3; k++)
                acc = fp8_mac(a[8*(3*(e/3)+k) +: 8], b[8*(3*k+e%3) +: 8], acc);
            c[8*e +: 8] = acc;
        end
        return c;
    endfunction

    // Behavioural fp_mac units; 0x5A marks a result sampled at the wrong time
    logic [7:0] p3a, p3b;
    assign bus0.mac_y = fp8_mac(bus0.mac_a, bus0.mac_b, bus0.mac_c);
    always_ff @(posedge clk) begin
        bus1.mac_y <= bus1.mac_valid ? fp8_mac(bus1.mac_a, bus1.mac_b, bus1.mac_c) : 8'h5A;
        p3a        <= bus3.mac_valid ? fp8_mac(bus3.mac_a, bus3.mac_b, bus3.mac_c) : 8'h5A;
        p3b        <= p3a;
        bus3.mac_y <= p3b;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue monitor on the MAC_LAT=1 instance
    logic        mon_on = 1'b0;
    logic [71:0] ref_a, ref_b;
    logic [7:0]  racc, xa, xb;
    int          me, mk, pulses;

    function automatic logic mon_skip(input int e, input int k);
`ifdef ZERO_SKIP_EN
        logic [7:0] ta, tb;
        ta = ref_a[8*(3*(e/3)+k) +: 8];
        tb = ref_b[8*(3*k+e%3) +: 8];
        return (ta[6:0] == 7'd0) || (tb[6:0] == 7'd0);
`else
        return (e < 0) || (k < 0);
`endif
    endfunction

    task automatic mon_step(input logic [7:0] y);
        racc = y;
        if (mk == 2) begin mk = 0; me++; racc = 8'h00; end
        else mk++;
    endtask

    always @(negedge clk) begin
        if (mon_on && bus1.mac_valid) begin
            pulses++;
            while (me < 9 && mon_skip(me, mk)) mon_step(racc);
            if (me >= 9) begin
                chk("pulse_overrun", 72'(me), 72'(8));
            end else begin
                xa = ref_a[8*(3*(me/3)+mk) +: 8];
                xb = ref_b[8*(3*mk+me%3) +: 8];
                chk($sformatf("mac_a e%0d k%0d", me, mk), 72'(bus1.mac_a), 72'(xa));
                chk($sformatf("mac_b e%0d k%0d", me, mk), 72'(bus1.mac_b), 72'(xb));
                chk($sformatf("mac_c e%0d k%0d", me, mk), 72'(bus1.mac_c), 72'(racc));
                mon_step(fp8_mac(xa, xb, racc));
            end
        end
    end

    function automatic logic done_of(input int which);
        case (which)
            0:       return bus0.done;
            3:       return bus3.done;
            default: return bus1.done;
        endcase
    endfunction

    task automatic mon_arm(input logic [71:0] a, input logic [71:0] b);
        ref_a = a; ref_b = b; me = 0; mk = 0; racc = 8'h00; pulses = 0; mon_on = 1'b1;
    endtask

    // Pulse start for one edge (t0); returns with time just after t0
    task automatic start_run(input int which, input logic [71:0] a, input logic [71:0] b, input logic hold);
        @(negedge clk);
        a_drv = a; b_drv = b;
        if (which == 1) mon_arm(a, b);
        case (which)
            0:       start0 = 1'b1;
            3:       start3 = 1'b1;
            default: start1 = 1'b1;
        endcase
        @(posedge clk); #1;
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; start3 = 1'b0; end
    endtask

    // lat counts cycles from t0; equals done cycle offset when done is seen
    task automatic wait_done(input int which, output int lat);
        lat = 1;
        while (!done_of(which) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    logic [71:0] a_id, a4, b2, c4;
    int          lat;

    initial begin
        a_id = {8'h30, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h30};
        b2   = {8'h20, 8'h30, 8'hA0, 8'h90, 8'h10, 8'h30, 8'h30, 8'h20, 8'hA7};
        a4   = {8'h27, 8'h38, 8'hB8, 8'h30, 8'h30, 8'hA0, 8'h20, 8'h90, 8'h10};
        c4   = ref_mm(a4, b2);
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        a_drv = '0; b_drv = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",      72'(bus1.busy),      72'(0));
        chk("reset done",      72'(bus1.done),      72'(0));
        chk("reset mac_valid", 72'(bus1.mac_valid), 72'(0));
        chk("reset mac_abc",   72'({bus1.mac_a, bus1.mac_b, bus1.mac_c}), 72'(0));
        chk("reset c_mat",     bus1.c_mat,          72'(0));
        @(negedge clk); rst = 1'b0;

        // Identity A: result reproduces B
        start_run(1, a_id, b2, 1'b0);
        chk("id busy at t0+1", 72'(bus1.busy), 72'(1));
        wait_done(1, lat);
        chk("id done latency", 72'(lat), 72'(LAT_ID));
        chk("id c_mat",        bus1.c_mat, b2);
        chk("id busy at done", 72'(bus1.busy), 72'(0));
        chk("id pulses",       72'(pulses), 72'(PULSES_ID));
        @(posedge clk); #1;
        chk("id done pulse width", 72'(bus1.done), 72'(0));

        // Reset mid-product clears the previous result as well
        start_run(1, a4, b2, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk); mon_on = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst busy",      72'(bus1.busy),      72'(0));
        chk("midrst done",      72'(bus1.done),      72'(0));
        chk("midrst mac_valid", 72'(bus1.mac_valid), 72'(0));
        chk("midrst mac_a",     72'(bus1.mac_a),     72'(0));
        chk("midrst c_mat",     bus1.c_mat,          72'(0));
        @(negedge clk); rst = 1'b0;

        // General operands on each latency
        start_run(1, a4, b2, 1'b0);
        wait_done(1, lat);
        chk("lat1 done latency", 72'(lat), 72'(55));
        chk("lat1 c_mat",        bus1.c_mat, c4);
        chk("lat1 pulses",       72'(pulses), 72'(27));

        start_run(0, a4, b2, 1'b0);
        wait_done(0, lat);
        chk("lat0 done latency", 72'(lat), 72'(28));
        chk("lat0 c_mat",        bus0.c_mat, c4);

        start_run(3, a4, b2, 1'b0);
        wait_done(3, lat);
        chk("lat3 done latency", 72'(lat), 72'(109));
        chk("lat3 c_mat",        bus3.c_mat, c4);

        // start held high: back-to-back runs, A changed mid-run is ignored
        start_run(1, a4, b2, 1'b1);
        wait_done(1, lat);
        chk("b2b first latency", 72'(lat), 72'(55));
        chk("b2b first c_mat",   bus1.c_mat, c4);
        @(posedge clk); #1;
        chk("b2b idle busy", 72'(bus1.busy), 72'(0));
        chk("b2b idle done", 72'(bus1.done), 72'(0));
        mon_arm(a4, b2);
        @(posedge clk); #1;
        chk("b2b restart busy", 72'(bus1.busy), 72'(1));
        start1 = 1'b0;
        a_drv  = a_id;
        wait_done(1, lat);
        chk("b2b second latency", 72'(lat), 72'(55));
        chk("b2b second c_mat",   bus1.c_mat, c4);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b stays idle", 72'(bus1.busy), 72'(0));
        mon_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
